// File: rtl/binary_search_ctrl_pkg.sv
// Shared definitions for the binary search controller.
//   DEFAULT_WIDTH : default comparator / search width
//   state_t       : 3-bit FSM state encoding (ST_IDLE .. ST_ERR)
package binary_search_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_EVAL  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/binary_search_ctrl_bounds.sv
// bs_bounds: holds the [lo, hi] search window of the binary search controller.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : reset window to [0, 2^WIDTH-1]
//   shrink_hi           : hi <= guess - 1 (caller guarantees guess != lo)
//   shrink_lo           : lo <= guess + 1 (caller guarantees guess != hi)
//   guess               : current trial value
//   mid                 : floor((lo + hi) / 2), computed without overflow
//   lo_hit / hi_hit     : guess equals lo / hi (window cannot shrink further)
module bs_bounds
  import binary_search_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shrink_hi,
  input  logic             shrink_lo,
  input  logic [WIDTH-1:0] guess,
  output logic [WIDTH-1:0] mid,
  output logic             lo_hit,
  output logic             hi_hit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_reg <= '0;
      hi_reg <= '0;
    end else if (load) begin
      lo_reg <= '0;
      hi_reg <= '1;
    end else if (shrink_hi) begin
      hi_reg <= guess - ONE;
    end else if (shrink_lo) begin
      lo_reg <= guess + ONE;
    end
  end

  // One extra bit keeps lo+hi from wrapping before the halving.
  assign sum    = {1'b0, lo_reg} + {1'b0, hi_reg};
  assign mid    = WIDTH'(sum >> 1);
  assign lo_hit = (guess == lo_reg);
  assign hi_hit = (guess == hi_reg);

endmodule

// File: rtl/binary_search_ctrl.sv
// binary_search_ctrl: successive-approximation search driving the B input of an
// external magnitude comparator whose A input carries the hidden value.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start                   : begin a search (honoured only in IDLE/DONE/ERR)
//   less, greater, equal    : comparator flags (hidden vs guess)
//   guess                   : registered trial value to comparator B
//   busy                    : search in progress (PROBE/EVAL)
//   done                    : search finished, found is valid
//   err                     : inconsistent flags or window exhausted
//   found                   : located value
//   steps                   : probes evaluated in current/last search
module binary_search_ctrl
  import binary_search_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              less,
  input  logic              greater,
  input  logic              equal,
  output logic [WIDTH-1:0]  guess,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  found,
  output logic [STEP_W-1:0] steps
);

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  guess_reg;
  logic [WIDTH-1:0]  found_reg;
  logic [STEP_W-1:0] steps_reg;

  logic             load, shrink_hi, shrink_lo;
  logic [WIDTH-1:0] mid;
  logic             lo_hit, hi_hit;
  logic             accept_start;
  logic             hit;

  bs_bounds #(.WIDTH(WIDTH)) u_bounds (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shrink_hi (shrink_hi),
    .shrink_lo (shrink_lo),
    .guess     (guess_reg),
    .mid       (mid),
    .lo_hit    (lo_hit),
    .hi_hit    (hi_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    shrink_hi    = 1'b0;
    shrink_lo    = 1'b0;
    accept_start = 1'b0;
    hit          = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          accept_start = 1'b1;
          load         = 1'b1;
          state_next   = ST_PROBE;
        end
      end
      ST_PROBE: state_next = ST_EVAL;
      ST_EVAL: begin
        // Exactly one flag must be set; anything else is a broken comparator.
        case ({less, greater, equal})
          3'b001: begin
            hit        = 1'b1;
            state_next = ST_DONE;
          end
          3'b100: begin
            if (lo_hit) state_next = ST_ERR;
            else begin
              shrink_hi  = 1'b1;
              state_next = ST_PROBE;
            end
          end
          3'b010: begin
            if (hi_hit) state_next = ST_ERR;
            else begin
              shrink_lo  = 1'b1;
              state_next = ST_PROBE;
            end
          end
          default: state_next = ST_ERR;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guess_reg <= '0;
      found_reg <= '0;
      steps_reg <= '0;
    end else begin
      if (accept_start)            steps_reg <= '0;
      if (state_reg == ST_PROBE)   guess_reg <= mid;
      if (state_reg == ST_EVAL)    steps_reg <= steps_reg + STEP_W'(1);
      if (hit)                     found_reg <= guess_reg;
    end
  end

  assign guess = guess_reg;
  assign found = found_reg;
  assign steps = steps_reg;
  assign busy  = (state_reg == ST_PROBE) || (state_reg == ST_EVAL);
  assign done  = (state_reg == ST_DONE);
  assign err   = (state_reg == ST_ERR);

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Randomized self-checking bench for binary_search_ctrl. A behavioural
// comparator model sits on the flag inputs; mode selects faulty comparators.
module tb_binary_search_ctrl;

  localparam int W  = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          less, greater, equal;
  logic [W-1:0]  guess, found;
  logic          busy, done, err;
  logic [SW-1:0] steps;

  int hidden = 0;
  int mode   = 0;   // 0 real comparator, 1 less stuck high, 2 less and greater high

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Comparator with A = hidden, B = guess.
  assign less    = (mode == 0) ? (hidden < int'(guess)) : 1'b1;
  assign greater = (mode == 0) ? (hidden > int'(guess)) : (mode == 2);
  assign equal   = (mode == 0) ? (hidden == int'(guess)) : 1'b0;

  binary_search_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .less    (less),
    .greater (greater),
    .equal   (equal),
    .guess   (guess),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .found   (found),
    .steps   (steps)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain binary search over integers with the same flag rules.
  task automatic model(input int hv, input int md, output int gq[$],
                       output int n, output bit ok, output bit bad);
    int lo = 0;
    int hi = (1 << W) - 1;
    bit l, g, e;
    gq = {}; n = 0; ok = 0; bad = 0;
    while (!ok && !bad && n < 16) begin
      int m = (lo + hi) / 2;
      gq.push_back(m);
      n++;
      l = (md == 0) ? (hv < m) : 1'b1;
      g = (md == 0) ? (hv > m) : (md == 2);
      e = (md == 0) && (hv == m);
      if (int'(l) + int'(g) + int'(e) != 1) bad = 1;
      else if (e) ok = 1;
      else if (l) begin
        if (m == lo) bad = 1; else hi = m - 1;
      end else begin
        if (m == hi) bad = 1; else lo = m + 1;
      end
    end
  endtask

  task automatic run_search(input int hv, input int md, input bit poke);
    int  exp_g[$];
    int  obs_g[$];
    int  exp_n, n;
    bit  exp_ok, exp_bad, fin;
    model(hv, md, exp_g, exp_n, exp_ok, exp_bad);
    hidden = hv;
    mode   = md;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_done_low", int'(done), 0);
    check("start_err_low", int'(err), 0);
    check("start_busy", int'(busy), 1);
    n = 0; fin = 0;
    for (int k = 0; k < 8 && !fin; k++) begin
      @(posedge clk); #1;
      obs_g.push_back(int'(guess));
      if (poke && k == 0) start = 1'b1;   // lands on an EVAL edge, must be ignored
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (done || err) fin = 1;
    end
    if (!fin) check("timeout", 0, 1);
    check("probe_count", obs_g.size(), exp_g.size());
    for (int i = 0; i < obs_g.size() && i < exp_g.size(); i++)
      check($sformatf("guess[%0d]", i), obs_g[i], exp_g[i]);
    check("edges_to_end", 2 * n, 2 * exp_n);
    check("steps", int'(steps), exp_n);
    check("done", int'(done), int'(exp_ok));
    check("err", int'(err), int'(exp_bad));
    check("busy_end", int'(busy), 0);
    if (exp_ok) check("found", int'(found), hv);
    $display("[TB] search hidden=%0d mode=%0d poke=%0d steps=%0d done=%0d err=%0d found=%0d",
             hv, md, poke, steps, done, err, found);
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_guess", int'(guess), 0);
    check("rst_found", int'(found), 0);
    check("rst_steps", int'(steps), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk); rst_n = 1'b1;
    $display("[TB] reset released");

    run_search(7, 0, 0);
    run_search(15, 0, 0);
    run_search(0, 0, 0);
    for (int v = 0; v < 16; v++) run_search(v, 0, 0);
    run_search(9, 1, 0);   // less stuck high: walks down to lo and errors
    run_search(9, 2, 0);   // two flags high on first EVAL
    run_search(4, 0, 0);   // recovery from ERR
    run_search(15, 0, 1);  // start pulsed while busy
    for (int r = 0; r < 20; r++) run_search(int'($urandom_range(0, 15)), 0, 0);

    // Asynchronous reset during EVAL of a hidden=12 search.
    hidden = 12; mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;    // now in EVAL with guess=7
    check("pre_rst_guess", int'(guess), 7);
    rst_n = 1'b0;
    #1;
    check("arst_guess", int'(guess), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_err", int'(err), 0);
    check("arst_found", int'(found), 0);
    check("arst_steps", int'(steps), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst_busy", int'(busy), 0);
    check("idle_after_rst_done", int'(done), 0);
    $display("[TB] mid-search reset checked");
    run_search(12, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/binary_search_ctrl.md
Name: binary_search_ctrl

Overview:
- Sequential search initiator that finds a hidden WIDTH-bit value by successive approximation.
- Drives a trial value `guess` into the B input of the team's existing combinational magnitude comparator. The hidden value is on the comparator's A input.
- Consumes the comparator's less/greater/equal flags and narrows a [lo, hi] window until equal asserts.
- Sits beside the comparator as its controlling end; used in lab top-levels and number-guessing demos.

Parameters:
- WIDTH, 4, bit width of guess/found (comparator width).
- STEP_W, 3, width of the probe counter. Must be at least clog2(WIDTH+2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a search. Sampled only in IDLE, DONE or ERR.
- less  in  1  comparator flag: hidden < guess.
- greater  in  1  comparator flag: hidden > guess.
- equal  in  1  comparator flag: hidden == guess.
- guess  out  WIDTH  registered trial value to comparator B.
- busy  out  1  high in PROBE and EVAL.
- done  out  1  high in DONE; found is valid.
- err  out  1  high in ERR: inconsistent flags or window exhausted.
- found  out  WIDTH  result. Valid while done is high.
- steps  out  STEP_W  number of probes evaluated in the current or last search.

Behaviour:
- Reset (rst_n low, asynchronous) clears state, guess, found, steps, lo and hi to 0. busy, done and err go to 0.
- Deasserting reset mid-search returns to IDLE; no resume.
- States: IDLE, PROBE, EVAL, DONE, ERR.
- IDLE / DONE / ERR with start=1:
  - lo <= 0, hi <= 2^WIDTH-1, steps <= 0, done <= 0, err <= 0.
  - Next state PROBE.
  - Without start, the state holds; found and steps are held.
- PROBE:
  - guess <= (lo+hi)>>1, computed with a WIDTH+1-bit sum with no overflow. The result floors.
  - Next state EVAL. This gives the comparator one full cycle to settle.
- EVAL samples less/greater/equal and increments steps.
  - Flags not exactly one-hot (none or more than one high) -> ERR.
  - equal -> found <= guess, go to DONE.
  - less:
    - If guess == lo -> ERR (window empty).
    - Otherwise hi <= guess-1, go to PROBE.
  - greater:
    - If guess == hi -> ERR.
    - Otherwise lo <= guess+1, go to PROBE.
- Subtract and add at the guess==lo / guess==hi boundaries never wrap, because those cases go to ERR first.
- start is ignored while busy.
- Latency: each probe takes 2 cycles. done rises 2·N clock edges after the edge that samples start, where N is the final steps value.
- N is at most WIDTH+1 (5 for WIDTH=4).
- guess holds its last value in DONE/ERR.
- Outputs are registered or decoded from the state register only. There is no combinational path from less/greater/equal to any output.

Decomposition:
- Shared package holds:
  - the state encoding constants ST_IDLE, ST_PROBE, ST_EVAL, ST_DONE, ST_ERR (3-bit);
  - the default WIDTH.
- One sub-module, bs_bounds:
  - holds the lo/hi registers;
  - takes load/shrink_hi/shrink_lo controls and the current guess;
  - outputs mid and the lo_hit/hi_hit flags.
- The FSM, guess, found and steps stay in binary_search_ctrl.
- The bench instantiates the existing comparator with A = hidden value and B = guess.

Test Plan:
- hidden=7, pulse start -> guess sequence 7; done at edge 2; found=7, steps=1, err=0.
- hidden=15 -> guesses 7,11,13,14,15; done after 10 edges; found=15, steps=5.
- hidden=0 -> guesses 7,3,1,0; found=0, steps=4. Then sweep all 16 values, each yielding found=hidden with steps ≤5.
- Bench forces less=1 always -> guesses 7,3,1,0; at guess 0 (==lo) enter ERR; err=1, done=0, steps=4. Flags less=greater=1 on the first EVAL -> ERR with steps=1.
- Reset and restart:
  - Pulse rst_n low during EVAL of a hidden=12 search -> all outputs 0 immediately, state IDLE.
  - start pulsed while busy -> ignored, search completes unchanged.
  - start in DONE -> new search, done drops next edge.
